// File: rtl/demux_pack_reg.sv
// demux_pack_reg: steers handshaked words into slots of a flat frame bus
// and presents the frame with valid/ready once every slot has been written.
module demux_pack_reg #(
  parameter int size = 8,
  parameter int n = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [size-1:0]          in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [n-1:0]             in_addr,
  input  logic                     addr_mode,
  input  logic                     clear,
  output logic [size*(2**n)-1:0]   frame_out,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [2**n-1:0]          fill_mask,
  output logic [n-1:0]             wr_ptr
);
  localparam int slots = 2**n;
  typedef enum logic {FILL, HOLD} state_t;
  state_t state_q, state_d;
  logic [size*slots-1:0] frame_q, frame_d;
  logic [slots-1:0] mask_q, mask_d;
  logic [n-1:0] ptr_q, ptr_d, tgt;
  assign in_ready = (state_q == FILL) && !clear && !rst;
  assign frame_valid = (state_q == HOLD);
  assign frame_out = frame_q;
  assign fill_mask = mask_q;
  assign wr_ptr = ptr_q;
  always_comb begin
    tgt = addr_mode ? in_addr : ptr_q;
    state_d = state_q;
    frame_d = frame_q;
    mask_d = mask_q;
    ptr_d = ptr_q;
    // frame_out is deliberately kept on abort/consume so a downstream selector sees stable data
    if (clear || (state_q == HOLD && frame_ready)) begin
      state_d = FILL;
      mask_d = '0;
      ptr_d = '0;
    end else if (in_valid && in_ready) begin
      frame_d[tgt*size +: size] = in_data;
      mask_d = mask_q | (slots'(1) << tgt);
      ptr_d = addr_mode ? ptr_q : ptr_q + 1'b1;
      state_d = &mask_d ? HOLD : FILL;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      frame_q <= '0;
      mask_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      mask_q <= mask_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_demux_pack_reg.sv
// tb_demux_pack_reg: directed + random stimulus against a slot-array model;
// completed frames are queued and checked by an independent monitor.
module tb_demux_pack_reg;
  logic clk = 0, rst = 1;
  logic [7:0] in_data = 0;
  logic in_valid = 0, addr_mode = 0, clear = 0, frame_ready = 0;
  logic [2:0] in_addr = 0;
  logic in_ready, frame_valid;
  logic [63:0] frame_out;
  logic [7:0] fill_mask;
  logic [2:0] wr_ptr;

  demux_pack_reg #(.size(8), .n(3)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .addr_mode(addr_mode), .clear(clear), .frame_out(frame_out),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .fill_mask(fill_mask), .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {logic [63:0] f; int c;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [7:0] mem [8];
  bit filled [8];
  int ptr = 0;
  bit hold = 0;
  logic fv_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_frame();
    logic [63:0] f;
    for (int j = 0; j < 8; j++) f[j*8 +: 8] = mem[j];
    return f;
  endfunction

  function automatic logic [7:0] model_mask();
    logic [7:0] m;
    for (int j = 0; j < 8; j++) m[j] = filled[j];
    return m;
  endfunction

  task automatic model_reset(input bit full);
    for (int j = 0; j < 8; j++) begin
      filled[j] = 0;
      if (full) mem[j] = 0;
    end
    ptr = 0;
    hold = 0;
  endtask

  // one clock: drive, check pre-edge outputs, clock, advance the model
  task automatic cycle(input bit v, input bit m, input int a, input logic [7:0] d, input bit clr, input bit fr);
    int t;
    bit all;
    exp_t e;
    in_valid = v; addr_mode = m; in_addr = a[2:0]; in_data = d; clear = clr; frame_ready = fr;
    #1;
    chk("in_ready", in_ready, !hold && !clr);
    chk("frame_valid", frame_valid, hold);
    chk("fill_mask", fill_mask, model_mask());
    chk("wr_ptr", wr_ptr, ptr);
    chk("frame_out", frame_out, pack_frame());
    @(posedge clk);
    #1;
    if (clr || (hold && fr)) model_reset(0);
    else if (!hold && v) begin
      t = m ? a % 8 : ptr;
      mem[t] = d;
      filled[t] = 1;
      if (!m) ptr = (ptr + 1) % 8;
      all = 1;
      for (int j = 0; j < 8; j++) all &= filled[j];
      if (all) begin
        hold = 1;
        e.f = pack_frame();
        e.c = cyc;
        sb.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) fv_prev <= 0;
    else begin
      if (frame_valid && !fv_prev) begin
        if (sb.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_frame", frame_out, e.f);
          chk("sb_latency", cyc, e.c);
        end
      end
      fv_prev <= frame_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset(1);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_frame_out", frame_out, 0);
    rst = 0;
    @(negedge clk);
    // auto fill, then backpressure
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'h10 + i[7:0], 0, 0);
    chk("auto_frame", frame_out, 64'h1716151413121110);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'hEE, 0, 0);
    chk("bp_frame", frame_out, 64'h1716151413121110);
    cycle(0, 0, 0, 0, 0, 1);
    chk("released_ready", in_ready, 1);
    chk("released_mask", fill_mask, 0);
    // explicit mode with overwrite of slot 5
    cycle(1, 1, 5, 8'hAA, 0, 0);
    cycle(1, 1, 5, 8'hBB, 0, 0);
    chk("overwrite_mask", fill_mask, 8'h20);
    chk("overwrite_fv", frame_valid, 0);
    for (int i = 0; i < 7; i++) cycle(1, 1, i < 5 ? i : i + 1, i[7:0], 0, 0);
    chk("explicit_slot5", frame_out[47:40], 8'hBB);
    chk("explicit_ptr", wr_ptr, 0);
    cycle(0, 0, 0, 0, 0, 1);
    // mixed modes
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'h30 + i[7:0], 0, 0);
    cycle(1, 1, 7, 8'h37, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'h33 + i[7:0], 0, 0);
    chk("mixed_ptr7", wr_ptr, 6);
    cycle(1, 0, 0, 8'h36, 0, 0);
    chk("mixed_frame", frame_out, 64'h3736353433323130);
    cycle(0, 0, 0, 0, 0, 1);
    // clear mid-fill, then clear in HOLD with frame_ready
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'h40 + i[7:0], 0, 0);
    cycle(1, 0, 0, 8'h99, 1, 0);
    chk("clear_mask", fill_mask, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'h50 + i[7:0], 0, 0);
    cycle(0, 0, 0, 0, 1, 1);
    chk("clear_hold_fv", frame_valid, 0);
    chk("clear_hold_frame", frame_out, 64'h5756555453525150);
    // async reset mid-frame
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'h60 + i[7:0], 0, 0);
    #2 rst = 1;
    #1;
    chk("arst_frame", frame_out, 0);
    chk("arst_mask", fill_mask, 0);
    chk("arst_ptr", wr_ptr, 0);
    chk("arst_fv", frame_valid, 0);
    chk("arst_ready", in_ready, 0);
    model_reset(1);
    @(negedge clk);
    rst = 0;
    // random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
            8'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 1));
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux_pack_reg.md
Name: demux_pack_reg

Overview:
- Write-side counterpart of the flat-bus word selector: accepts one size-bit word per handshake and steers it into one of 2**n slots of a flat output bus of size*(2**n) bits.
- Slot j occupies bits [j*size +: size], the same packing the selector uses, so the output feeds a selector directly.
- A slot-valid mask tracks filled slots. When every slot is filled, the block presents the frame with a valid/ready handshake and stalls input until the frame is consumed.

Parameters:
- size, 8, bits per word/slot
- n, 3, slot-index width; slot count = 2**n

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_data  input  size  word to store
- in_valid  input  1  in_data/in_addr valid this cycle
- in_ready  output  1  block can accept a word this cycle
- in_addr  input  n  target slot; used only when addr_mode=1
- addr_mode  input  1  0 = auto-increment pointer, 1 = explicit in_addr
- clear  input  1  synchronous abort: empty mask, pointer to 0
- frame_out  output  size*(2**n)  packed slot registers
- frame_valid  output  1  all slots filled, frame presented
- frame_ready  input  1  downstream consumes frame
- fill_mask  output  2**n  bit j = slot j written since last frame/clear
- wr_ptr  output  n  auto-increment pointer

Behaviour:
- Reset (async, rst=1): state=FILL; frame_out=0, fill_mask=0, wr_ptr=0, frame_valid=0. in_ready is 1 once rst deasserts.
- States: FILL, HOLD.
- in_ready = (state==FILL) && !clear. frame_valid = (state==HOLD).
- Accept: in_valid && in_ready at a rising edge.
- Target slot: tgt = addr_mode ? in_addr : wr_ptr.
- On accept, at the same edge:
  - frame_out[tgt*size +: size] <= in_data
  - fill_mask[tgt] <= 1
  - if addr_mode=0: wr_ptr <= wr_ptr+1, modulo 2**n, wrapping from 2**n-1 to 0
  - explicit-mode accepts leave wr_ptr unchanged
- Overwrite: an explicit write to an already-filled slot replaces its data; the mask is unchanged. Mixed auto/explicit writes are legal.
- FILL->HOLD: at the accepting edge where (fill_mask | onehot(tgt)) is all ones. frame_valid rises the following cycle, i.e. 1 cycle after the final accept.
- HOLD:
  - in_ready=0, frame_out stable, input ignored.
  - frame_valid stays high until frame_valid && frame_ready at an edge.
  - On that edge: fill_mask<=0, wr_ptr<=0, state<=FILL. frame_out retains old data.
  - New words are accepted the next cycle, so there is a 1-cycle bubble.
- clear=1 (synchronous, highest priority below rst):
  - from any state: fill_mask<=0, wr_ptr<=0, state<=FILL; frame_valid drops the next cycle
  - frame_out is not modified
  - no word is accepted that cycle
  - clear in HOLD aborts the frame even if frame_ready=1 the same cycle
- Widths: all indexing is modulo 2**n; there are no out-of-range slots. size*(2**n) is computed at elaboration.
- rst mid-frame: immediate return to reset values; the partial frame is lost.
- frame_ready while in FILL: ignored.

Test Plan:
- size=8, n=3, auto mode: send 0x10..0x17 on consecutive cycles with in_valid=1. Required:
  - frame_valid=1 exactly 1 cycle after the 8th accept
  - frame_out=0x1716151413121110
  - in_ready=0 while frame_valid=1
- Backpressure: hold frame_ready=0 for 5 cycles after frame_valid. Required:
  - frame_out and frame_valid stable throughout
  - in_valid words are not accepted
  - after frame_ready=1 for one edge: fill_mask=0, wr_ptr=0, in_ready=1 the next cycle
- Explicit mode:
  - write slot 5=0xAA, slot 5=0xBB, then slots 0,1,2,3,4,6,7 with 0x00..0x06
  - required: no frame_valid after the two slot-5 writes (fill_mask=0x20); frame_valid after the slot-7 write; slot 5 reads 0xBB; wr_ptr stays 0
- Mixed modes:
  - auto-write 3 words (slots 0-2, wr_ptr=3), then explicit slot 7, then auto ×4 (slots 3-6)
  - required: frame completes on the final auto write (wr_ptr=7 at that point); frame_valid follows 1 cycle later
- Clear:
  - after 4 auto writes, pulse clear with in_valid=1: the word is not accepted, fill_mask=0, wr_ptr=0
  - in HOLD, clear with frame_ready=1: frame_valid=0 the next cycle, frame_out unchanged
- Async reset: assert rst between clock edges mid-frame. Required: all outputs 0 without waiting for a clk edge; normal fill resumes after deassert.
